// File: rtl/lm32_insn_injector_if.sv
// Command and injection bus for the LM32 instruction injector.
//
// Handshakes:
//   cmd side: a command transfers on a rising edge where cmd_valid_i && cmd_ready_o.
//             cmd_ready_o does not depend on cmd_valid_i. A command offered while
//             cmd_ready_o is low is not taken.
//   inj side: an instruction issues on a rising edge where inj_valid_o && !stall_d_i.
//             inj_instruction_o is stable while inj_valid_o is high and stall_d_i holds it.
interface lm32_insn_injector_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [5:0]  cmd_op_i;
  logic [4:0]  cmd_r3_i;
  logic [4:0]  cmd_r2_i;
  logic [4:0]  cmd_r1_i;
  logic [25:0] cmd_imm_i;
  logic        inj_valid_o;
  logic [31:0] inj_instruction_o;
  logic        stall_d_i;

  // Debug controller / decode-stage side
  modport master (
    output cmd_valid_i, cmd_op_i, cmd_r3_i, cmd_r2_i, cmd_r1_i, cmd_imm_i, stall_d_i,
    input  cmd_ready_o, inj_valid_o, inj_instruction_o
  );

  // Injector side
  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_r3_i, cmd_r2_i, cmd_r1_i, cmd_imm_i, stall_d_i,
    output cmd_ready_o, inj_valid_o, inj_instruction_o
  );
endinterface

// File: rtl/lm32_insn_injector.sv
// LM32 instruction injector: encodes decoded command fields into instruction
// words, queues them in a show-ahead FIFO, presents them to the D stage and
// tracks injected instructions until they retire from W.
module lm32_insn_injector #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 flush_i,
  lm32_insn_injector_if.slave  bus,
  input  logic                 valid_w,
  input  logic                 kill_w,
  output logic [15:0]          issued_count_o,
  output logic [15:0]          killed_count_o,
  output logic [2:0]           in_flight_o,
  output logic                 busy_o,
  output logic                 error_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [2:0]  MAX_IF_C  = 3'(MAX_INFLIGHT);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [2:0]    in_flight_q, in_flight_d;
  logic [15:0]   issued_q, issued_d;
  logic [15:0]   killed_q, killed_d;
  logic          error_q, error_d;

  logic          empty, full, push, pop, retire, retire_ok;
  logic [31:0]   enc_word;

  // Field packing by opcode class; unused immediate bits are dropped.
  function automatic logic [31:0] encode(input logic [5:0] op, input logic [4:0] r3,
                                         input logic [4:0] r2, input logic [4:0] r1,
                                         input logic [25:0] imm);
    logic [31:0] w;
    if (op == 6'h00 || op == 6'h0f)
      w = {op, r3, r2, 11'b0, imm[4:0]};
    else if (!op[5])
      w = {op, r3, r2, imm[15:0]};
    else if (op == 6'h2b || op == 6'h38 || op == 6'h3e)
      w = {op, imm};
    else
      w = {op, r3, r2, r1, 11'b0};
    return w;
  endfunction

  assign enc_word = encode(bus.cmd_op_i, bus.cmd_r3_i, bus.cmd_r2_i, bus.cmd_r1_i, bus.cmd_imm_i);

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign push      = bus.cmd_valid_i && !full;
  assign pop       = bus.inj_valid_o && !bus.stall_d_i;
  assign retire    = valid_w && enable_i;
  assign retire_ok = retire && (in_flight_q != 3'd0);

  assign bus.cmd_ready_o       = !full;
  assign bus.inj_valid_o       = !empty && enable_i && (in_flight_q < MAX_IF_C);
  assign bus.inj_instruction_o = empty ? 32'h0 : mem_q[rd_ptr_q];

  assign issued_count_o = issued_q;
  assign killed_count_o = killed_q;
  assign in_flight_o    = in_flight_q;
  assign busy_o         = !empty || (in_flight_q != 3'd0);
  assign error_o        = error_q;

  // Next-state for FIFO pointers, occupancy, counters and the error flag.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    in_flight_d = in_flight_q;
    issued_d    = issued_q;
    killed_d    = killed_q;
    error_d     = error_q;

    if (flush_i) begin
      // Flush wins over a same-cycle push; a same-cycle issue still counts below.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end

    if (pop) issued_d = issued_q + 16'd1;
    if (retire && kill_w) killed_d = killed_q + 16'd1;
    if (retire && (in_flight_q == 3'd0)) error_d = 1'b1;

    if (pop && !retire_ok)      in_flight_d = in_flight_q + 3'd1;
    else if (!pop && retire_ok) in_flight_d = in_flight_q - 3'd1;
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_flight_q <= '0;
      issued_q    <= '0;
      killed_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      issued_q    <= issued_d;
      killed_q    <= killed_d;
      error_q     <= error_d;
    end
  end

  // FIFO storage; the encoded word is captured at push time. Flush overrides the push.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= enc_word;
  end
endmodule

// File: tb/tb_lm32_insn_injector.sv
// Directed testbench for lm32_insn_injector: an encoding vector table plus
// hand-written sequences for latency, backpressure, in-flight limit, retire
// accounting, flush and asynchronous reset.
module tb_lm32_insn_injector;
  logic        clk;
  logic        rst_i;
  logic        enable;
  logic        flush;
  logic        valid_w;
  logic        kill_w;
  logic [15:0] issued_count;
  logic [15:0] killed_count;
  logic [2:0]  in_flight;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  r3;
    logic [4:0]  r2;
    logic [4:0]  r1;
    logic [25:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  lm32_insn_injector_if bus();

  lm32_insn_injector #(.DEPTH(4), .MAX_INFLIGHT(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .enable_i       (enable),
    .flush_i        (flush),
    .bus            (bus.slave),
    .valid_w        (valid_w),
    .kill_w         (kill_w),
    .issued_count_o (issued_count),
    .killed_count_o (killed_count),
    .in_flight_o    (in_flight),
    .busy_o         (busy),
    .error_o        (error)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input int idx);
    bus.cmd_op_i  = vecs[idx].op;
    bus.cmd_r3_i  = vecs[idx].r3;
    bus.cmd_r2_i  = vecs[idx].r2;
    bus.cmd_r1_i  = vecs[idx].r1;
    bus.cmd_imm_i = vecs[idx].imm;
  endtask

  // Driver: offer one command for one clock edge.
  task automatic push(input int idx);
    set_cmd(idx);
    bus.cmd_valid_i = 1'b1;
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic retire_pulse(input logic kill);
    valid_w = 1'b1;
    kill_w  = kill;
    tick();
    valid_w = 1'b0;
    kill_w  = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " cmd_ready"},   32'(bus.cmd_ready_o), 32'd1);
    chk({tag, " inj_valid"},   32'(bus.inj_valid_o), 32'd0);
    chk({tag, " inj_instr"},   bus.inj_instruction_o, 32'h0);
    chk({tag, " issued"},      32'(issued_count), 32'd0);
    chk({tag, " killed"},      32'(killed_count), 32'd0);
    chk({tag, " in_flight"},   32'(in_flight), 32'd0);
    chk({tag, " busy"},        32'(busy), 32'd0);
    chk({tag, " error"},       32'(error), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{6'h0d, 5'd3,  5'd2,  5'd0,  26'h0001234, 32'h34621234};
    vecs[1]  = '{6'h2d, 5'd3,  5'd2,  5'd1,  26'h0000000, 32'hB4620800};
    vecs[2]  = '{6'h2b, 5'd0,  5'd0,  5'd0,  26'h0000007, 32'hAC000007};
    vecs[3]  = '{6'h0f, 5'd2,  5'd1,  5'd0,  26'h0000025, 32'h3C410005};
    vecs[4]  = '{6'h00, 5'd5,  5'd6,  5'd7,  26'h3FFFFE3, 32'h00A60003};
    vecs[5]  = '{6'h01, 5'd31, 5'd31, 5'd31, 26'h3FFABCD, 32'h07FFABCD};
    vecs[6]  = '{6'h38, 5'd1,  5'd1,  5'd1,  26'h2AAAAAA, 32'hE2AAAAAA};
    vecs[7]  = '{6'h3e, 5'd0,  5'd0,  5'd0,  26'h3FFFFFF, 32'hFBFFFFFF};
    vecs[8]  = '{6'h20, 5'd1,  5'd2,  5'd3,  26'h3FFFFFF, 32'h80221800};
    vecs[9]  = '{6'h3f, 5'd31, 5'd0,  5'd31, 26'h0000000, 32'hFFE0F800};
    vecs[10] = '{6'h1f, 5'd0,  5'd0,  5'd0,  26'h0010000, 32'h7C000000};

    rst_i = 1'b0;
    enable = 1'b0;
    flush = 1'b0;
    valid_w = 1'b0;
    kill_w = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.stall_d_i = 1'b0;
    set_cmd(0);

    // Reset state
    tick();
    tick();
    chk_reset_values("reset");
    rst_i = 1'b1;
    tick();

    // Encoding table: push with injection off, read the held head, flush it away.
    for (int i = 0; i < 11; i++) begin
      push(i);
      chk($sformatf("enc[%0d] word", i), bus.inj_instruction_o, vecs[i].exp);
      chk($sformatf("enc[%0d] valid_off", i), 32'(bus.inj_valid_o), 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk($sformatf("enc[%0d] flushed", i), bus.inj_instruction_o, 32'h0);
    end

    // Latency 1 after push, hold under stall, then issue and retire.
    enable = 1'b1;
    bus.stall_d_i = 1'b1;
    push(0);
    chk("lat valid", 32'(bus.inj_valid_o), 32'd1);
    chk("lat word", bus.inj_instruction_o, 32'h34621234);
    tick();
    chk("stall hold valid", 32'(bus.inj_valid_o), 32'd1);
    chk("stall no issue", 32'(issued_count), 32'd0);
    bus.stall_d_i = 1'b0;
    tick();
    chk("issue count", 32'(issued_count), 32'd1);
    chk("issue in_flight", 32'(in_flight), 32'd1);
    chk("issue valid drop", 32'(bus.inj_valid_o), 32'd0);
    retire_pulse(1'b0);
    chk("retire in_flight", 32'(in_flight), 32'd0);
    chk("retire busy", 32'(busy), 32'd0);

    // Fill while disabled; the fifth push is dropped.
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(vecs[i + 1].exp);
      push(i + 1);
      if (i == 3) chk("full ready", 32'(bus.cmd_ready_o), 32'd0);
    end
    chk("full busy", 32'(busy), 32'd1);
    enable = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      chk($sformatf("order[%0d] valid", i), 32'(bus.inj_valid_o), 32'd1);
      chk($sformatf("order[%0d] word", i), bus.inj_instruction_o, e);
      tick();
    end
    chk("drain empty word", bus.inj_instruction_o, 32'h0);
    chk("drain issued", 32'(issued_count), 32'd5);
    chk("max in_flight", 32'(in_flight), 32'd4);
    chk("drain ready", 32'(bus.cmd_ready_o), 32'd1);

    // In-flight limit: queued word waits until one retirement.
    push(5);
    chk("limit valid", 32'(bus.inj_valid_o), 32'd0);
    chk("limit head", bus.inj_instruction_o, 32'h07FFABCD);
    retire_pulse(1'b0);
    chk("limit retire in_flight", 32'(in_flight), 32'd3);
    chk("limit reopen valid", 32'(bus.inj_valid_o), 32'd1);
    tick();
    chk("limit issued", 32'(issued_count), 32'd6);
    chk("limit in_flight back", 32'(in_flight), 32'd4);
    retire_pulse(1'b1);
    chk("kill count", 32'(killed_count), 32'd1);
    chk("kill in_flight", 32'(in_flight), 32'd3);

    // Issue and retire in the same cycle leave in_flight unchanged.
    push(6);
    chk("same valid", 32'(bus.inj_valid_o), 32'd1);
    valid_w = 1'b1;
    tick();
    chk("same in_flight", 32'(in_flight), 32'd3);
    chk("same issued", 32'(issued_count), 32'd7);
    tick();
    tick();
    tick();
    valid_w = 1'b0;
    chk("drain in_flight", 32'(in_flight), 32'd0);
    chk("drain busy", 32'(busy), 32'd0);
    chk("drain no error", 32'(error), 32'd0);
    chk("drain killed", 32'(killed_count), 32'd1);

    // valid_w ignored while disabled; underflow sets sticky error.
    enable = 1'b0;
    retire_pulse(1'b0);
    chk("disabled retire error", 32'(error), 32'd0);
    enable = 1'b1;
    retire_pulse(1'b0);
    chk("underflow error", 32'(error), 32'd1);
    chk("underflow in_flight", 32'(in_flight), 32'd0);
    tick();
    tick();
    chk("error sticky", 32'(error), 32'd1);

    // Flush with queued words and a concurrent push; in_flight survives.
    push(7);
    tick();
    chk("pre-flush issued", 32'(issued_count), 32'd8);
    chk("pre-flush in_flight", 32'(in_flight), 32'd1);
    enable = 1'b0;
    push(8);
    push(9);
    push(10);
    set_cmd(0);
    bus.cmd_valid_i = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.cmd_valid_i = 1'b0;
    chk("flush word", bus.inj_instruction_o, 32'h0);
    chk("flush ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("flush busy", 32'(busy), 32'd1);
    chk("flush in_flight", 32'(in_flight), 32'd1);
    enable = 1'b1;
    #1;
    chk("flush no valid", 32'(bus.inj_valid_o), 32'd0);
    retire_pulse(1'b0);
    chk("flush busy clear", 32'(busy), 32'd0);
    chk("flush issued kept", 32'(issued_count), 32'd8);

    // Asynchronous reset in the middle of issuing.
    push(1);
    push(2);
    chk("mid issued", 32'(issued_count), 32'd9);
    chk("mid valid", 32'(bus.inj_valid_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk_reset_values("async");
    #1;
    rst_i = 1'b1;
    tick();
    chk("post reset word", bus.inj_instruction_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
